// File: rtl/decode_pkg.sv
// decode_pkg: shared encodings for the parametrised decode stage.
//   br_type_e   - branch/jump kind supplied by the external decoder
//   dst_sel_e   - destination register selector
//   pc_src_e    - next-PC source reported to fetch
//   idex_flags_t and IDEX_BUBBLE - flag set written into ID/EX on a bubble
package decode_pkg;

   localparam int XLEN_DEF   = 32;
   localparam int NREG_DEF   = 32;
   localparam int CTRL_W_DEF = 14;
   localparam int AW_DEF     = $clog2(NREG_DEF);

   typedef enum logic [2:0] {
      BR_NONE = 3'd0,
      BR_BEQ  = 3'd1,
      BR_BNE  = 3'd2,
      BR_BLEZ = 3'd3,
      BR_BGTZ = 3'd4,
      BR_J    = 3'd5,
      BR_JR   = 3'd6
   } br_type_e;

   typedef enum logic [1:0] {
      DST_NONE = 2'd0,
      DST_RT   = 2'd1,
      DST_RD   = 2'd2,
      DST_R31  = 2'd3
   } dst_sel_e;

   typedef enum logic [1:0] {
      PC_SEQ    = 2'd0,
      PC_BRANCH = 2'd1,
      PC_JUMP   = 2'd2,
      PC_REG    = 2'd3
   } pc_src_e;

   typedef struct packed {
      logic valid;
      logic we;
      logic is_load;
   } idex_flags_t;

   localparam idex_flags_t IDEX_BUBBLE = '{valid: 1'b0, we: 1'b0, is_load: 1'b0};

   // Branch kinds that read a register in ID and therefore need the operand
   // to be final before they can resolve (plain j does not).
   function automatic logic br_reads_regs(input logic [2:0] t);
      return (t == BR_BEQ) || (t == BR_BNE) || (t == BR_BLEZ) ||
             (t == BR_BGTZ) || (t == BR_JR);
   endfunction

endpackage

// File: rtl/decode_stage_p_if.sv
// decode_stage_p_if: bundle of all decode-stage signals except clk/rst_n.
//   master modport - upstream side (IF/ID, decoder, WB, EX/MEM, fetch)
//   slave  modport - the decode stage itself
interface decode_stage_p_if #(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 14
);
   localparam int AW = $clog2(NREG);

   logic              ifid_valid;
   logic [31:0]       ifid_ins;
   logic [XLEN-1:0]   ifid_pc4;
   logic [CTRL_W-1:0] ctrl_in;
   logic [1:0]        dst_sel;
   logic              uses_rs;
   logic              uses_rt;
   logic              is_load;
   logic [2:0]        br_type;
   logic              wb_we;
   logic [AW-1:0]     wb_addr;
   logic [XLEN-1:0]   wb_data;
   logic              exmem_we;
   logic [AW-1:0]     exmem_rd;
   logic              exmem_is_load;
   logic [XLEN-1:0]   exmem_data;
   logic              flush;

   logic              stall_out;
   logic [1:0]        pc_src;
   logic [XLEN-1:0]   target;
   logic              idex_valid;
   logic              idex_we;
   logic              idex_is_load;
   logic [CTRL_W-1:0] idex_ctrl;
   logic [XLEN-1:0]   idex_rs_data;
   logic [XLEN-1:0]   idex_rt_data;
   logic [XLEN-1:0]   idex_imm;
   logic [XLEN-1:0]   idex_pc4;
   logic [AW-1:0]     idex_rs;
   logic [AW-1:0]     idex_rt;
   logic [AW-1:0]     idex_dst;
   logic [15:0]       stall_cnt;

   modport master (
      output ifid_valid, ifid_ins, ifid_pc4, ctrl_in, dst_sel, uses_rs, uses_rt,
             is_load, br_type, wb_we, wb_addr, wb_data, exmem_we, exmem_rd,
             exmem_is_load, exmem_data, flush,
      input  stall_out, pc_src, target, idex_valid, idex_we, idex_is_load,
             idex_ctrl, idex_rs_data, idex_rt_data, idex_imm, idex_pc4,
             idex_rs, idex_rt, idex_dst, stall_cnt
   );

   modport slave (
      input  ifid_valid, ifid_ins, ifid_pc4, ctrl_in, dst_sel, uses_rs, uses_rt,
             is_load, br_type, wb_we, wb_addr, wb_data, exmem_we, exmem_rd,
             exmem_is_load, exmem_data, flush,
      output stall_out, pc_src, target, idex_valid, idex_we, idex_is_load,
             idex_ctrl, idex_rs_data, idex_rt_data, idex_imm, idex_pc4,
             idex_rs, idex_rt, idex_dst, stall_cnt
   );

endinterface

// File: rtl/regfile_p.sv
// regfile_p: NREG x XLEN register file, two combinational read ports and one
// clocked write port. r0 always reads 0; a write in the same cycle to the
// address being read is passed straight through to the read port.
//   i_clk              clock
//   i_we/i_waddr/i_wdata  write port
//   i_raddr_a/o_rdata_a   read port A
//   i_raddr_b/o_rdata_b   read port B
module regfile_p #(
   parameter int XLEN = 32,
   parameter int NREG = 32,
   parameter int AW   = $clog2(NREG)
) (
   input  logic            i_clk,
   input  logic            i_we,
   input  logic [AW-1:0]   i_waddr,
   input  logic [XLEN-1:0] i_wdata,
   input  logic [AW-1:0]   i_raddr_a,
   output logic [XLEN-1:0] o_rdata_a,
   input  logic [AW-1:0]   i_raddr_b,
   output logic [XLEN-1:0] o_rdata_b
);

   logic [XLEN-1:0] r_mem [NREG];
   logic            w_wr_en;

   assign w_wr_en = i_we && (i_waddr != '0);

   always_ff @(posedge i_clk) begin
      if (w_wr_en)
         r_mem[i_waddr] <= i_wdata;
   end

   always_comb begin
      o_rdata_a = r_mem[i_raddr_a];
      if (i_raddr_a == '0)
         o_rdata_a = '0;
      else if (w_wr_en && (i_waddr == i_raddr_a))
         o_rdata_a = i_wdata;
   end

   always_comb begin
      o_rdata_b = r_mem[i_raddr_b];
      if (i_raddr_b == '0)
         o_rdata_b = '0;
      else if (w_wr_en && (i_waddr == i_raddr_b))
         o_rdata_b = i_wdata;
   end

endmodule

// File: rtl/decode_stage_p.sv
// decode_stage_p: instruction-decode stage. Reads operands (with EX/MEM
// forwarding), resolves branches/jumps in ID, detects load-use and branch
// hazards, and registers the result into the ID/EX pipeline register.
//   clk, rst_n  clock and asynchronous active-low reset
//   bus         decode_stage_p_if.slave; IF/ID contents, decoder flags, WB
//               write port and EX/MEM state in; stall/next-PC and ID/EX out
module decode_stage_p
   import decode_pkg::*;
#(
   parameter int XLEN   = 32,
   parameter int NREG   = 32,
   parameter int CTRL_W = 14
) (
   input  logic clk,
   input  logic rst_n,
   decode_stage_p_if.slave bus
);

   localparam int AW = $clog2(NREG);

   logic [AW-1:0]     w_rs, w_rt, w_rd, w_dst;
   logic [XLEN-1:0]   w_rf_rs, w_rf_rt, w_rs_val, w_rt_val;
   logic [XLEN-1:0]   w_imm, w_br_tgt, w_j_tgt, w_target;
   logic              w_rs_live, w_rt_live;
   logic              w_fwd_rs, w_fwd_rt;
   logic              w_ex_rs, w_ex_rt, w_mem_ld_rs, w_mem_ld_rt;
   logic              w_load_use, w_br_haz, w_stall, w_issue, w_we;
   logic              w_eq, w_rs_le0;
   pc_src_e           w_pc_sel;
   logic              w_unused;

   idex_flags_t       r_flags;
   logic [CTRL_W-1:0] r_ctrl;
   logic [XLEN-1:0]   r_rs_data, r_rt_data, r_imm, r_pc4;
   logic [AW-1:0]     r_rs, r_rt, r_dst;
   logic [15:0]       r_stall_cnt;

   // opcode bits are decoded outside this stage
   assign w_unused = ^bus.ifid_ins[31:26];

   assign w_rs = AW'(bus.ifid_ins[25:21]);
   assign w_rt = AW'(bus.ifid_ins[20:16]);
   assign w_rd = AW'(bus.ifid_ins[15:11]);

   regfile_p #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
      .i_clk     (clk),
      .i_we      (bus.wb_we),
      .i_waddr   (bus.wb_addr),
      .i_wdata   (bus.wb_data),
      .i_raddr_a (w_rs),
      .o_rdata_a (w_rf_rs),
      .i_raddr_b (w_rt),
      .o_rdata_b (w_rf_rt)
   );

   // EX/MEM forwarding; a load's data is not ready yet, so it is never used
   assign w_fwd_rs = bus.exmem_we && !bus.exmem_is_load &&
                     (bus.exmem_rd != '0) && (bus.exmem_rd == w_rs);
   assign w_fwd_rt = bus.exmem_we && !bus.exmem_is_load &&
                     (bus.exmem_rd != '0) && (bus.exmem_rd == w_rt);
   assign w_rs_val = w_fwd_rs ? bus.exmem_data : w_rf_rs;
   assign w_rt_val = w_fwd_rt ? bus.exmem_data : w_rf_rt;

   assign w_imm    = {{(XLEN-16){bus.ifid_ins[15]}}, bus.ifid_ins[15:0]};
   assign w_br_tgt = bus.ifid_pc4 + (w_imm << 2);
   assign w_j_tgt  = {bus.ifid_pc4[XLEN-1:28], bus.ifid_ins[25:0], 2'b00};

   always_comb begin
      w_dst = '0;
      case (dst_sel_e'(bus.dst_sel))
         DST_RT:  w_dst = w_rt;
         DST_RD:  w_dst = w_rd;
         DST_R31: w_dst = AW'(31);
         default: w_dst = '0;
      endcase
   end
   assign w_we = (bus.dst_sel != DST_NONE) && (w_dst != '0);

   // Hazard detection: only operands that are actually read and nonzero count
   assign w_rs_live   = bus.uses_rs && (w_rs != '0);
   assign w_rt_live   = bus.uses_rt && (w_rt != '0);
   assign w_ex_rs     = r_flags.valid && r_flags.we && (r_dst == w_rs) && w_rs_live;
   assign w_ex_rt     = r_flags.valid && r_flags.we && (r_dst == w_rt) && w_rt_live;
   assign w_mem_ld_rs = bus.exmem_we && bus.exmem_is_load &&
                        (bus.exmem_rd == w_rs) && w_rs_live;
   assign w_mem_ld_rt = bus.exmem_we && bus.exmem_is_load &&
                        (bus.exmem_rd == w_rt) && w_rt_live;

   assign w_load_use = r_flags.is_load && (w_ex_rs || w_ex_rt);
   assign w_br_haz   = br_reads_regs(bus.br_type) &&
                       (w_ex_rs || w_ex_rt || w_mem_ld_rs || w_mem_ld_rt);
   assign w_stall    = bus.ifid_valid && (w_load_use || w_br_haz);
   assign w_issue    = bus.ifid_valid && !w_stall && !bus.flush;

   assign w_eq     = (w_rs_val == w_rt_val);
   assign w_rs_le0 = w_rs_val[XLEN-1] || (w_rs_val == '0);

   always_comb begin
      w_pc_sel = PC_SEQ;
      w_target = w_br_tgt;
      case (br_type_e'(bus.br_type))
         BR_BEQ:  if (w_eq)      w_pc_sel = PC_BRANCH;
         BR_BNE:  if (!w_eq)     w_pc_sel = PC_BRANCH;
         BR_BLEZ: if (w_rs_le0)  w_pc_sel = PC_BRANCH;
         BR_BGTZ: if (!w_rs_le0) w_pc_sel = PC_BRANCH;
         BR_J: begin
            w_pc_sel = PC_JUMP;
            w_target = w_j_tgt;
         end
         BR_JR: begin
            w_pc_sel = PC_REG;
            w_target = w_rs_val;
         end
         default: w_pc_sel = PC_SEQ;
      endcase
   end

   assign bus.stall_out = w_stall && !bus.flush;
   assign bus.pc_src    = w_issue ? w_pc_sel : PC_SEQ;
   assign bus.target    = w_target;

   // ID/EX register: data fields always load, flags/ctrl are zeroed on a bubble
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_flags     <= IDEX_BUBBLE;
         r_ctrl      <= '0;
         r_rs_data   <= '0;
         r_rt_data   <= '0;
         r_imm       <= '0;
         r_pc4       <= '0;
         r_rs        <= '0;
         r_rt        <= '0;
         r_dst       <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_issue) begin
            r_flags <= '{valid: 1'b1, we: w_we, is_load: bus.is_load};
            r_ctrl  <= bus.ctrl_in;
         end else begin
            r_flags <= IDEX_BUBBLE;
            r_ctrl  <= '0;
         end
         r_rs_data <= w_rs_val;
         r_rt_data <= w_rt_val;
         r_imm     <= w_imm;
         r_pc4     <= bus.ifid_pc4;
         r_rs      <= w_rs;
         r_rt      <= w_rt;
         r_dst     <= w_dst;
         if (w_stall && !bus.flush && (r_stall_cnt != 16'hFFFF))
            r_stall_cnt <= r_stall_cnt + 16'd1;
      end
   end

   assign bus.idex_valid   = r_flags.valid;
   assign bus.idex_we      = r_flags.we;
   assign bus.idex_is_load = r_flags.is_load;
   assign bus.idex_ctrl    = r_ctrl;
   assign bus.idex_rs_data = r_rs_data;
   assign bus.idex_rt_data = r_rt_data;
   assign bus.idex_imm     = r_imm;
   assign bus.idex_pc4     = r_pc4;
   assign bus.idex_rs      = r_rs;
   assign bus.idex_rt      = r_rt;
   assign bus.idex_dst     = r_dst;
   assign bus.stall_cnt    = r_stall_cnt;

endmodule

// File: tb/tb_decode_stage_p.sv
// tb_decode_stage_p: directed self-checking bench for decode_stage_p.
module tb_decode_stage_p;
   import decode_pkg::*;

   logic clk;
   logic rst_n;
   int   errors = 0;
   int   checks = 0;

   decode_stage_p_if #(.XLEN(32), .NREG(32), .CTRL_W(14)) bus ();

   decode_stage_p #(.XLEN(32), .NREG(32), .CTRL_W(14)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                        input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                        input logic [4:0] rd);
      return {6'd0, rs, rt, rd, 5'd0, 6'h20};
   endfunction

   task automatic clr_id();
      bus.ifid_valid = 1'b0;
      bus.ifid_ins   = '0;
      bus.ifid_pc4   = '0;
      bus.ctrl_in    = '0;
      bus.dst_sel    = '0;
      bus.uses_rs    = 1'b0;
      bus.uses_rt    = 1'b0;
      bus.is_load    = 1'b0;
      bus.br_type    = '0;
      bus.flush      = 1'b0;
   endtask

   task automatic set_id(input logic [31:0] ins, input logic [31:0] pc4, input logic [1:0] dsel,
                         input logic urs, input logic urt, input logic ld,
                         input logic [2:0] br, input logic [13:0] ctrl);
      bus.ifid_valid = 1'b1;
      bus.ifid_ins   = ins;
      bus.ifid_pc4   = pc4;
      bus.dst_sel    = dsel;
      bus.uses_rs    = urs;
      bus.uses_rt    = urt;
      bus.is_load    = ld;
      bus.br_type    = br;
      bus.ctrl_in    = ctrl;
   endtask

   task automatic wb_write(input logic [4:0] a, input logic [31:0] d);
      bus.wb_we   = 1'b1;
      bus.wb_addr = a;
      bus.wb_data = d;
      tick();
      bus.wb_we   = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      clr_id();
      bus.wb_we = 1'b0; bus.wb_addr = '0; bus.wb_data = '0;
      bus.exmem_we = 1'b0; bus.exmem_rd = '0; bus.exmem_is_load = 1'b0; bus.exmem_data = '0;
      #1;
      chk("rst_valid", bus.idex_valid, 0);
      chk("rst_we", bus.idex_we, 0);
      chk("rst_ctrl", bus.idex_ctrl, 0);
      chk("rst_rsdata", bus.idex_rs_data, 0);
      chk("rst_cnt", bus.stall_cnt, 0);
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;

      wb_write(5'd1, 32'h11);
      wb_write(5'd2, 32'h22);
      wb_write(5'd4, 32'h0);
      wb_write(5'd8, 32'h7);
      wb_write(5'd31, 32'h400);
      wb_write(5'd10, 32'h8000_0000);

      // add r6,r5,r0 while WB writes r5
      set_id(mk_r(5'd5, 5'd0, 5'd6), 32'h40, DST_RD, 1, 1, 0, BR_NONE, 14'h0123);
      bus.wb_we = 1'b1; bus.wb_addr = 5'd5; bus.wb_data = 32'h1234_5678;
      #1;
      chk("byp_stall", bus.stall_out, 0);
      tick();
      bus.wb_we = 1'b0;
      chk("byp_rsdata", bus.idex_rs_data, 32'h1234_5678);
      chk("byp_rtdata", bus.idex_rt_data, 0);
      chk("byp_dst", bus.idex_dst, 6);
      chk("byp_we", bus.idex_we, 1);
      chk("byp_valid", bus.idex_valid, 1);
      chk("byp_ctrl", bus.idex_ctrl, 14'h0123);
      chk("byp_imm", bus.idex_imm, 32'h0000_3020);
      chk("byp_pc4", bus.idex_pc4, 32'h40);
      chk("byp_rs", bus.idex_rs, 5);

      // lw r2,0(r1) then add r3,r2,r1
      set_id(mk_i(6'h23, 5'd1, 5'd2, 16'h0), 32'h44, DST_RT, 1, 0, 1, BR_NONE, 14'h00AA);
      #1;
      chk("lw_stall", bus.stall_out, 0);
      tick();
      chk("lw_isload", bus.idex_is_load, 1);
      chk("lw_dst", bus.idex_dst, 2);
      chk("lw_rsdata", bus.idex_rs_data, 32'h11);
      set_id(mk_r(5'd2, 5'd1, 5'd3), 32'h48, DST_RD, 1, 1, 0, BR_NONE, 14'h0155);
      #1;
      chk("lu_stall", bus.stall_out, 1);
      chk("lu_pcsrc", bus.pc_src, 0);
      tick();
      chk("lu_bub_valid", bus.idex_valid, 0);
      chk("lu_bub_we", bus.idex_we, 0);
      chk("lu_bub_ctrl", bus.idex_ctrl, 0);
      chk("lu_cnt1", bus.stall_cnt, 1);
      bus.exmem_we = 1'b1; bus.exmem_rd = 5'd2; bus.exmem_is_load = 1'b1; bus.exmem_data = 32'hDEAD;
      #1;
      chk("lu_release", bus.stall_out, 0);
      tick();
      chk("lu_issue_valid", bus.idex_valid, 1);
      chk("lu_issue_dst", bus.idex_dst, 3);
      chk("lu_no_ld_fwd", bus.idex_rs_data, 32'h22);
      chk("lu_rtdata", bus.idex_rt_data, 32'h11);
      chk("lu_ctrl", bus.idex_ctrl, 14'h0155);
      chk("lu_cnt_hold", bus.stall_cnt, 1);

      // beq r4,r8,+3 with r4=7 forwarded from EX/MEM
      bus.exmem_we = 1'b1; bus.exmem_rd = 5'd4; bus.exmem_is_load = 1'b0; bus.exmem_data = 32'h7;
      set_id(mk_i(6'h04, 5'd4, 5'd8, 16'd3), 32'h100, DST_NONE, 1, 1, 0, BR_BEQ, 14'h0);
      #1;
      chk("beq_stall", bus.stall_out, 0);
      chk("beq_pcsrc", bus.pc_src, 1);
      chk("beq_target", bus.target, 32'h10C);
      bus.exmem_we = 1'b0;
      #1;
      chk("beq_nofwd_pcsrc", bus.pc_src, 0);
      bus.exmem_we = 1'b1;
      tick();
      chk("beq_valid", bus.idex_valid, 1);
      chk("beq_we", bus.idex_we, 0);
      chk("beq_rsdata", bus.idex_rs_data, 32'h7);
      chk("beq_imm", bus.idex_imm, 32'h3);

      // bne r4,r0 with a load to r4 in EX/MEM
      bus.exmem_we = 1'b1; bus.exmem_rd = 5'd4; bus.exmem_is_load = 1'b1; bus.exmem_data = 32'h99;
      set_id(mk_i(6'h05, 5'd4, 5'd0, 16'd2), 32'h200, DST_NONE, 1, 1, 0, BR_BNE, 14'h0);
      #1;
      chk("bld_stall", bus.stall_out, 1);
      chk("bld_pcsrc", bus.pc_src, 0);
      tick();
      chk("bld_bub", bus.idex_valid, 0);
      chk("bld_cnt2", bus.stall_cnt, 2);
      bus.exmem_we = 1'b0;
      bus.wb_we = 1'b1; bus.wb_addr = 5'd4; bus.wb_data = 32'h55;
      #1;
      chk("bld_release", bus.stall_out, 0);
      chk("bld_pcsrc2", bus.pc_src, 1);
      chk("bld_target", bus.target, 32'h208);
      tick();
      bus.wb_we = 1'b0;
      chk("bld_valid", bus.idex_valid, 1);
      chk("bld_rsdata", bus.idex_rs_data, 32'h55);

      // beq r9,r0,-1 while add r9 sits in ID/EX
      set_id(mk_r(5'd1, 5'd1, 5'd9), 32'h2FC, DST_RD, 1, 1, 0, BR_NONE, 14'h0);
      tick();
      chk("add9_dst", bus.idex_dst, 9);
      set_id(mk_i(6'h04, 5'd9, 5'd0, 16'hFFFF), 32'h300, DST_NONE, 1, 1, 0, BR_BEQ, 14'h0);
      #1;
      chk("bex_stall", bus.stall_out, 1);
      tick();
      chk("bex_cnt3", bus.stall_cnt, 3);
      chk("bex_bub", bus.idex_valid, 0);
      bus.wb_we = 1'b1; bus.wb_addr = 5'd9; bus.wb_data = 32'h0;
      #1;
      chk("bex_release", bus.stall_out, 0);
      chk("bex_pcsrc", bus.pc_src, 1);
      chk("bex_target_neg", bus.target, 32'h2FC);
      tick();
      bus.wb_we = 1'b0;
      chk("bex_imm", bus.idex_imm, 32'hFFFF_FFFF);

      // blez / bgtz on negative, zero and positive rs
      set_id(mk_i(6'h06, 5'd10, 5'd0, 16'd4), 32'h1000, DST_NONE, 1, 0, 0, BR_BLEZ, 14'h0);
      #1;
      chk("blez_neg", bus.pc_src, 1);
      chk("blez_target", bus.target, 32'h1010);
      bus.br_type = BR_BGTZ;
      #1;
      chk("bgtz_neg", bus.pc_src, 0);
      bus.ifid_ins = mk_i(6'h07, 5'd0, 5'd0, 16'd4);
      #1;
      chk("bgtz_zero", bus.pc_src, 0);
      bus.br_type = BR_BLEZ;
      #1;
      chk("blez_zero", bus.pc_src, 1);
      bus.ifid_ins = mk_i(6'h07, 5'd1, 5'd0, 16'd4);
      bus.br_type = BR_BGTZ;
      #1;
      chk("bgtz_pos", bus.pc_src, 1);

      // j
      set_id({6'h02, 26'h0123456}, 32'hA000_0010, DST_NONE, 0, 0, 0, BR_J, 14'h0);
      #1;
      chk("j_pcsrc", bus.pc_src, 2);
      chk("j_target", bus.target, 32'hA048_D158);

      // jr r31, then the same with flush
      set_id({6'd0, 5'd31, 15'd0, 6'h08}, 32'h500, DST_NONE, 1, 0, 0, BR_JR, 14'h0);
      #1;
      chk("jr_pcsrc", bus.pc_src, 3);
      chk("jr_target", bus.target, 32'h400);
      bus.flush = 1'b1;
      #1;
      chk("jrf_pcsrc", bus.pc_src, 0);
      chk("jrf_stall", bus.stall_out, 0);
      tick();
      chk("jrf_bub", bus.idex_valid, 0);
      chk("jrf_cnt", bus.stall_cnt, 3);

      // flush over a stall condition, then a long forced stall
      bus.exmem_we = 1'b1; bus.exmem_rd = 5'd4; bus.exmem_is_load = 1'b1;
      set_id(mk_i(6'h05, 5'd4, 5'd0, 16'd2), 32'h200, DST_NONE, 1, 1, 0, BR_BNE, 14'h0);
      bus.flush = 1'b1;
      #1;
      chk("fl_stall", bus.stall_out, 0);
      tick();
      chk("fl_cnt", bus.stall_cnt, 3);
      chk("fl_bub", bus.idex_valid, 0);
      bus.flush = 1'b0;
      #1;
      chk("st_stall", bus.stall_out, 1);
      repeat (65531) tick();
      chk("st_cnt_fffe", bus.stall_cnt, 16'hFFFE);
      tick();
      chk("st_cnt_ffff", bus.stall_cnt, 16'hFFFF);
      repeat (4468) tick();
      chk("st_cnt_sat", bus.stall_cnt, 16'hFFFF);
      chk("st_stall_hold", bus.stall_out, 1);

      // reset in the middle of the stall
      #2 rst_n = 1'b0;
      #1;
      chk("rs_cnt", bus.stall_cnt, 0);
      chk("rs_valid", bus.idex_valid, 0);
      chk("rs_stall", bus.stall_out, 1);
      #1 rst_n = 1'b1;
      bus.exmem_we = 1'b0;
      clr_id();
      tick();
      chk("rs_cnt_after", bus.stall_cnt, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
